// File: rtl/desc_sched_if.sv
// Port bundle for desc_sched: keypoint input, local_desc engine control and descriptor stream.
interface desc_sched_if #(
    parameter int unsigned KP_DEPTH = 8
);
    logic                      kp_valid;
    logic                      kp_ready;
    logic [17:0]               kp_addr;
    logic [5:0]                kp_dir;
    logic                      ld_start;
    logic [17:0]               ld_addr_kp;
    logic [5:0]                ld_main_dir;
    logic                      ld_sample_en;
    logic                      ld_done;
    logic [3:0]                ld_desc_sel;
    logic [63:0]               ld_desc;
    logic                      desc_valid;
    logic                      desc_ready;
    logic [63:0]               desc_data;
    logic                      desc_last;
    logic [17:0]               desc_kp_addr;
    logic                      busy;
    logic                      err_timeout;
    logic [$clog2(KP_DEPTH):0] kp_count;

    modport slave (
        input  kp_valid, kp_addr, kp_dir, ld_done, ld_desc, desc_ready,
        output kp_ready, ld_start, ld_addr_kp, ld_main_dir, ld_sample_en, ld_desc_sel,
               desc_valid, desc_data, desc_last, desc_kp_addr, busy, err_timeout, kp_count
    );

    modport master (
        output kp_valid, kp_addr, kp_dir, ld_done, ld_desc, desc_ready,
        input  kp_ready, ld_start, ld_addr_kp, ld_main_dir, ld_sample_en, ld_desc_sel,
               desc_valid, desc_data, desc_last, desc_kp_addr, busy, err_timeout, kp_count
    );
endinterface

// File: rtl/desc_sched.sv
// Keypoint scheduler and descriptor drain controller for the local_desc engine:
// queues keypoints, runs the engine once per keypoint and streams out its descriptor words.
module desc_sched #(
    parameter int unsigned KP_DEPTH   = 8,
    parameter int unsigned WIN_CYCLES = 256,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned DESC_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    desc_sched_if.slave bus
);
    localparam int unsigned PtrW = $clog2(KP_DEPTH);
    localparam int unsigned CntW = $clog2(KP_DEPTH) + 1;
    localparam int unsigned SmpW = $clog2(WIN_CYCLES + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    localparam logic [SmpW-1:0] SmpLast = SmpW'(WIN_CYCLES - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
    localparam logic [3:0]      SelLast = 4'(DESC_WORDS - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(KP_DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StSample, StWait, StDrain} state_e;

    state_e          state_q;
    logic [23:0]     fifo_mem [KP_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [SmpW-1:0] smp_cnt_q;
    logic [WdW-1:0]  wd_cnt_q;
    logic [17:0]     addr_q;
    logic [17:0]     desc_addr_q;
    logic [5:0]      dir_q;
    logic [3:0]      sel_q;
    logic            start_q;
    logic            sample_en_q;
    logic            valid_q;
    logic            last_q;
    logic            err_q;
    logic            push;
    logic            pop;
    logic            accept;

    // Ready is derived from the registered count, so a pop from a full queue frees it next cycle.
    assign bus.kp_ready = (count_q != CntFull);
    assign push         = bus.kp_valid && bus.kp_ready;
    assign pop          = (state_q == StIdle) && (count_q != '0);
    assign accept       = valid_q && bus.desc_ready;

    assign bus.kp_count     = count_q;
    assign bus.busy         = (state_q != StIdle) || (count_q != '0);
    assign bus.ld_start     = start_q;
    assign bus.ld_addr_kp   = addr_q;
    assign bus.ld_main_dir  = dir_q;
    assign bus.ld_sample_en = sample_en_q;
    assign bus.ld_desc_sel  = sel_q;
    assign bus.desc_valid   = valid_q;
    assign bus.desc_data    = bus.ld_desc;
    assign bus.desc_last    = last_q;
    assign bus.desc_kp_addr = desc_addr_q;
    assign bus.err_timeout  = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.kp_addr, bus.kp_dir};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            smp_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            addr_q      <= '0;
            desc_addr_q <= '0;
            dir_q       <= '0;
            sel_q       <= '0;
            start_q     <= 1'b0;
            sample_en_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
            start_q <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        {addr_q, dir_q} <= fifo_mem[rd_ptr_q];
                        desc_addr_q     <= fifo_mem[rd_ptr_q][23:6];
                        start_q         <= 1'b1;
                        state_q         <= StLoad;
                    end
                end
                StLoad: begin
                    smp_cnt_q   <= '0;
                    sample_en_q <= 1'b1;
                    state_q     <= StSample;
                end
                StSample: begin
                    if (smp_cnt_q == SmpLast) begin
                        sample_en_q <= 1'b0;
                        wd_cnt_q    <= '0;
                        state_q     <= StWait;
                    end else begin
                        smp_cnt_q <= smp_cnt_q + SmpW'(1);
                    end
                end
                StWait: begin
                    // Completion beats the watchdog when both land in the same cycle.
                    if (bus.ld_done) begin
                        sel_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (SelLast == 4'd0);
                        state_q <= StDrain;
                    end else if (wd_cnt_q == WdLast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WdW'(1);
                    end
                end
                StDrain: begin
                    if (accept) begin
                        if (last_q) begin
                            sel_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            sel_q  <= sel_q + 4'd1;
                            last_q <= ((sel_q + 4'd1) == SelLast);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_desc_sched.sv
// Directed bench for desc_sched: single keypoint, full queue, backpressure, timeout,
// done at the timeout edge and reset mid-drain.
module tb_desc_sched;
    localparam int unsigned KpDepth   = 8;
    localparam int unsigned WinCycles = 16;
    localparam int unsigned Timeout   = 64;
    localparam int unsigned DescWords = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    desc_sched_if #(.KP_DEPTH(KpDepth)) bus ();

    desc_sched #(
        .KP_DEPTH  (KpDepth),
        .WIN_CYCLES(WinCycles),
        .TIMEOUT   (Timeout),
        .DESC_WORDS(DescWords)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: word i of a descriptor is desc_base + i.
    logic [63:0] desc_base;
    int          done_delay;
    int          stray_cyc;
    int          ready_mode;
    assign bus.ld_desc = desc_base + 64'(bus.ld_desc_sel);

    // Event logs, written only by the monitor.
    logic [63:0] words[$];
    bit          lasts[$];
    int          word_cyc[$];
    logic [17:0] last_addr[$];
    int          start_cyc[$];
    int          err_cyc[$];
    int          wentry_cyc[$];
    int          n_sample = 0;
    int          n_valid = 0;
    int          n_stall = 0;
    int          stall_bad = 0;
    logic        prev_sample = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [3:0]  prev_sel;

    always @(negedge clk) begin
        if (bus.ld_start) start_cyc.push_back(cyc);
        if (bus.ld_sample_en) n_sample++;
        if (prev_sample && !bus.ld_sample_en) wentry_cyc.push_back(cyc);
        if (bus.err_timeout) err_cyc.push_back(cyc);
        if (bus.desc_valid) n_valid++;
        if (prev_stall && bus.desc_valid) begin
            n_stall++;
            if (bus.desc_data !== prev_data || bus.ld_desc_sel !== prev_sel) stall_bad++;
        end
        if (bus.desc_valid && bus.desc_ready) begin
            words.push_back(bus.desc_data);
            lasts.push_back(bus.desc_last);
            word_cyc.push_back(cyc);
            if (bus.desc_last) last_addr.push_back(bus.desc_kp_addr);
        end
        prev_sample = bus.ld_sample_en;
        prev_stall  = bus.desc_valid && !bus.desc_ready;
        prev_data   = bus.desc_data;
        prev_sel    = bus.ld_desc_sel;
    end

    bit eng_sampling = 1'b0;
    bit eng_waiting = 1'b0;
    int eng_wcnt = 0;
    int rdy_pat = 0;

    initial begin
        bus.ld_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ld_done = 1'b0;
            if (rst) begin
                eng_sampling = 1'b0;
                eng_waiting  = 1'b0;
            end else if (bus.ld_sample_en) begin
                eng_sampling = 1'b1;
                eng_waiting  = 1'b0;
            end else if (eng_sampling) begin
                eng_sampling = 1'b0;
                eng_waiting  = 1'b1;
                eng_wcnt     = 0;
            end else if (eng_waiting) begin
                eng_wcnt++;
            end
            if (eng_waiting && done_delay >= 0 && eng_wcnt == done_delay) begin
                bus.ld_done = 1'b1;
                eng_waiting = 1'b0;
            end
            if (cyc == stray_cyc) bus.ld_done = 1'b1;
        end
    end

    initial begin
        bus.desc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                bus.desc_ready = 1'b1;
            end else begin
                bus.desc_ready = (rdy_pat == 0);
                rdy_pat = (rdy_pat + 1) % 3;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    task automatic push_kp(input logic [17:0] a, input logic [5:0] d);
        int n = 0;
        bus.kp_valid = 1'b1;
        bus.kp_addr  = a;
        bus.kp_dir   = d;
        while (!bus.kp_ready && n < 500) begin
            tick();
            n++;
        end
        if (!bus.kp_ready) check("push_ready_bound", 0, 1);
        tick();
        bus.kp_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (words.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, words.size(), n);
    endtask

    initial begin
        int c0, b, s0, w0, e0, l0, v0, ns0, sb0, smp0, bad;
        rst = 1'b1;
        desc_base = 64'h1000;
        done_delay = 5;
        stray_cyc = -1;
        ready_mode = 0;
        bus.kp_valid = 1'b0;
        bus.kp_addr = '0;
        bus.kp_dir = '0;

        // Reset state
        tick();
        tick();
        check("rst_kp_ready", bus.kp_ready, 1);
        check("rst_kp_count", bus.kp_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_desc_valid", bus.desc_valid, 0);
        check("rst_ld_start", bus.ld_start, 0);
        rst = 1'b0;
        tick();

        // Single keypoint
        b = words.size(); s0 = start_cyc.size(); w0 = wentry_cyc.size();
        l0 = last_addr.size(); smp0 = n_sample;
        c0 = cyc;
        bus.kp_valid = 1'b1;
        bus.kp_addr = 18'd10020;
        bus.kp_dir = 6'd3;
        tick();
        bus.kp_valid = 1'b0;
        check("c1_kp_count", bus.kp_count, 1);
        tick();
        check("c2_ld_start", bus.ld_start, 1);
        check("c2_ld_addr_kp", bus.ld_addr_kp, 10020);
        check("c2_ld_main_dir", bus.ld_main_dir, 3);
        wait_words(b + 16, 200, "single_words");
        check("single_start_cyc", at(start_cyc, s0) - c0, 2);
        check("single_n_start", start_cyc.size() - s0, 1);
        check("single_sample_cycles", n_sample - smp0, 16);
        check("single_wait_entry", at(wentry_cyc, w0) - c0, 19);
        check("single_first_word", at(word_cyc, b) - c0, 25);
        check("single_last_word", at(word_cyc, b + 15) - c0, 40);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("single_word%0d", i),
                  (b + i < words.size()) ? words[b + i] : 64'hx, 64'h1000 + 64'(i));
            check($sformatf("single_last%0d", i),
                  (b + i < lasts.size()) ? 64'(lasts[b + i]) : 64'hx, (i == 15) ? 1 : 0);
        end
        check("single_desc_kp_addr", (l0 < last_addr.size()) ? last_addr[l0] : 18'h3ffff, 10020);
        check("single_idle_busy", bus.busy, 0);
        check("single_addr_held", bus.ld_addr_kp, 10020);

        // Queue full
        done_delay = 2;
        b = words.size(); l0 = last_addr.size();
        push_kp(18'd100, 6'd1);
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) push_kp(18'(200 + i), 6'(i));
        check("full_kp_count", bus.kp_count, 8);
        check("full_kp_ready", bus.kp_ready, 0);
        push_kp(18'd208, 6'd8);
        check("full_ninth_after_pop", words.size() - b, 16);
        wait_words(b + 160, 1500, "full_words");
        for (int k = 0; k < 10; k++) begin
            check($sformatf("full_order%0d", k),
                  (l0 + k < last_addr.size()) ? last_addr[l0 + k] : 18'h3ffff,
                  (k == 0) ? 100 : 200 + k - 1);
        end

        // Backpressure 1,0,0 during drain
        desc_base = 64'h2000;
        done_delay = 0;
        ready_mode = 1;
        b = words.size(); ns0 = n_stall; sb0 = stall_bad;
        push_kp(18'd600, 6'd9);
        wait_words(b + 16, 300, "bp_words");
        repeat (5) tick();
        check("bp_accept_count", words.size() - b, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (b + i >= words.size() || words[b + i] !== 64'h2000 + 64'(i)) bad++;
        end
        check("bp_word_order", bad, 0);
        check("bp_stall_seen", (n_stall - ns0) > 0, 1);
        check("bp_stall_stable", stall_bad - sb0, 0);
        check("bp_last", (b + 15 < lasts.size()) ? 64'(lasts[b + 15]) : 64'hx, 1);
        ready_mode = 0;
        tick();

        // Timeout, with a stray done during SAMPLE
        done_delay = -1;
        s0 = start_cyc.size(); w0 = wentry_cyc.size(); e0 = err_cyc.size(); v0 = n_valid;
        push_kp(18'd300, 6'd4);
        push_kp(18'd301, 6'd5);
        stray_cyc = cyc + 5;
        repeat (200) tick();
        check("to_err_pulses", err_cyc.size() - e0, 2);
        check("to_err_cycle", at(err_cyc, e0) - at(wentry_cyc, w0), 64);
        check("to_err_cycle2", at(err_cyc, e0 + 1) - at(wentry_cyc, w0 + 1), 64);
        check("to_next_start", at(start_cyc, s0 + 1) - at(wentry_cyc, w0), 65);
        check("to_no_valid", n_valid - v0, 0);
        check("to_idle", bus.busy, 0);
        stray_cyc = -1;

        // Done in the 64th WAIT cycle
        done_delay = 63;
        desc_base = 64'h3000;
        b = words.size(); w0 = wentry_cyc.size(); e0 = err_cyc.size(); l0 = last_addr.size();
        push_kp(18'd410, 6'd7);
        wait_words(b + 16, 300, "edge_words");
        check("edge_no_err", err_cyc.size() - e0, 0);
        check("edge_first_word", at(word_cyc, b) - at(wentry_cyc, w0), 64);
        check("edge_kp_addr", (l0 < last_addr.size()) ? last_addr[l0] : 18'h3ffff, 410);

        // Reset mid-drain with three keypoints queued
        done_delay = 0;
        desc_base = 64'h4000;
        b = words.size();
        push_kp(18'd500, 6'd0);
        push_kp(18'd501, 6'd1);
        push_kp(18'd502, 6'd2);
        push_kp(18'd503, 6'd3);
        check("rd_queued", bus.kp_count, 3);
        wait_words(b + 8, 200, "rd_words");
        rst = 1'b1;
        tick();
        check("rd_kp_count", bus.kp_count, 0);
        check("rd_desc_valid", bus.desc_valid, 0);
        check("rd_busy", bus.busy, 0);
        check("rd_kp_ready", bus.kp_ready, 1);
        check("rd_desc_last", bus.desc_last, 0);
        rst = 1'b0;
        s0 = start_cyc.size(); l0 = last_addr.size();
        repeat (60) tick();
        check("rd_no_start", start_cyc.size() - s0, 0);
        check("rd_no_last", last_addr.size() - l0, 0);
        check("rd_still_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles, limit 20000", cyc);
        $fatal(1, "bench time limit reached");
    end
endmodule
